fetch_unit: RTL and testbench

Instruction fetch stage that produces the fields latched by the fetch/decode pipeline register. It owns the program counter, reads 16-bit instruction words from instruction memory over a req/ack handshake, and fetches a second immediate word for two-word opcodes. It presents one decoded instruction at a time, holds it under `stall`, and restarts from a new address on `redirect`.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory handshake, pipeline control and decoded
// instruction fields exchanged between the fetch stage and its environment.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_addr;
  logic              inst_valid;
  logic [31:0]       Next_inst_addr;
  logic [4:0]        opcode;
  logic [2:0]        Rs;
  logic [2:0]        Rd;
  logic [4:0]        shmnt;
  logic [15:0]       imm;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr, inst_valid, Next_inst_addr,
           opcode, Rs, Rd, shmnt, imm,
    input  imem_ack, imem_rdata, stall, redirect, redirect_addr
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req, imem_addr, inst_valid, Next_inst_addr,
           opcode, Rs, Rd, shmnt, imm,
    output imem_ack, imem_rdata, stall, redirect, redirect_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one- or two-word instructions over a
// req/ack memory port and presents one decoded instruction at a time.
// Optional feature macro: FETCH_RESET_VECTOR_EN loads the start PC from
// memory words 0 (high half) and 1 (low half) after reset.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 20,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
`ifdef FETCH_RESET_VECTOR_EN
    ST_VEC_HI,
    ST_VEC_LO,
`endif
    ST_FETCH1,
    ST_FETCH2,
    ST_PRESENT
  } state_e;

`ifdef FETCH_RESET_VECTOR_EN
  localparam state_e      ST_FIRST = ST_VEC_HI;
  localparam logic [31:0] PC_INIT  = 32'h0000_0000;
`else
  localparam state_e      ST_FIRST = ST_FETCH1;
  localparam logic [31:0] PC_INIT  = RESET_PC;
`endif

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       next_q, next_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [2:0]        rs_q, rs_d;
  logic [2:0]        rd_q, rd_d;
  logic [4:0]        sh_q, sh_d;
  logic [15:0]       imm_q, imm_d;

  logic ack_ok;
  logic two_word;
  logic vec_busy;

  // An ack only counts against a request we are actually driving
  assign ack_ok   = req_q & bus.imem_ack;
  assign two_word = (bus.imem_rdata[15:14] == 2'b11);

`ifdef FETCH_RESET_VECTOR_EN
  assign vec_busy = (state_q == ST_VEC_HI) || (state_q == ST_VEC_LO);
`else
  assign vec_busy = 1'b0;
`endif

  // Next-state, PC/field updates, and registered request/address decode
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    next_d   = next_q;
    valid_d  = valid_q;
    opcode_d = opcode_q;
    rs_d     = rs_q;
    rd_d     = rd_q;
    sh_d     = sh_q;
    imm_d    = imm_q;
    req_d    = 1'b0;
    addr_d   = addr_q;

    if (bus.redirect && !vec_busy) begin
      // Redirect drops whatever is in flight, including a same-cycle ack
      pc_d    = bus.redirect_addr;
      valid_d = 1'b0;
      state_d = ST_FETCH1;
    end else begin
      case (state_q)
`ifdef FETCH_RESET_VECTOR_EN
        ST_VEC_HI: begin
          if (ack_ok) begin
            pc_d[31:16] = bus.imem_rdata;
            state_d     = ST_VEC_LO;
          end
        end
        ST_VEC_LO: begin
          if (ack_ok) begin
            pc_d[15:0] = bus.imem_rdata;
            state_d    = ST_FETCH1;
          end
        end
`endif
        ST_FETCH1: begin
          if (ack_ok) begin
            opcode_d = bus.imem_rdata[15:11];
            rs_d     = bus.imem_rdata[10:8];
            rd_d     = bus.imem_rdata[7:5];
            sh_d     = bus.imem_rdata[4:0];
            next_d   = pc_q + (two_word ? 32'd2 : 32'd1);
            if (two_word) begin
              state_d = ST_FETCH2;
            end else begin
              imm_d   = 16'h0000;
              valid_d = 1'b1;
              state_d = ST_PRESENT;
            end
          end
        end
        ST_FETCH2: begin
          if (ack_ok) begin
            imm_d   = bus.imem_rdata;
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (!bus.stall) begin
            pc_d    = next_q;
            valid_d = 1'b0;
            state_d = ST_FETCH1;
          end
        end
        default: state_d = ST_FIRST;
      endcase
    end

    // Request/address are registered from the state being entered
    case (state_d)
`ifdef FETCH_RESET_VECTOR_EN
      ST_VEC_HI: begin
        req_d  = 1'b1;
        addr_d = '0;
      end
      ST_VEC_LO: begin
        req_d  = 1'b1;
        addr_d = ADDR_W'(1);
      end
`endif
      ST_FETCH1: begin
        req_d  = 1'b1;
        addr_d = pc_d[ADDR_W-1:0];
      end
      ST_FETCH2: begin
        req_d  = 1'b1;
        addr_d = ADDR_W'(pc_d + 32'd1);
      end
      default: begin
        req_d  = 1'b0;
        addr_d = addr_q;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FIRST;
      pc_q     <= PC_INIT;
      next_q   <= 32'h0000_0000;
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      opcode_q <= 5'h00;
      rs_q     <= 3'h0;
      rd_q     <= 3'h0;
      sh_q     <= 5'h00;
      imm_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      next_q   <= next_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      rs_q     <= rs_d;
      rd_q     <= rd_d;
      sh_q     <= sh_d;
      imm_q    <= imm_d;
    end
  end

  assign bus.imem_req       = req_q;
  assign bus.imem_addr      = addr_q;
  assign bus.inst_valid     = valid_q;
  assign bus.Next_inst_addr = next_q;
  assign bus.opcode         = opcode_q;
  assign bus.Rs             = rs_q;
  assign bus.Rd             = rd_q;
  assign bus.shmnt          = sh_q;
  assign bus.imm            = imm_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stall/redirect/wait-state
// traffic; a program-level model predicts the instruction stream into a
// queue that an independent monitor pops on every consumed instruction.
module tb_fetch_unit;
  localparam int unsigned AW = 20;

  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] next;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_consumed = 0;
  int   cyc = 0;

  fetch_unit_if #(.ADDR_W(AW)) bus ();

  fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- memory image and program-level model ----------------
  logic [15:0] mem [int unsigned];
  exp_t        exp_q [$];

  function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
    if (!mem.exists(32'(a))) mem[32'(a)] = 16'($urandom);
    return mem[32'(a)];
  endfunction

  // Instruction that starts at program address pc
  function automatic exp_t decode_at(input logic [31:0] pc);
    exp_t        e;
    logic [15:0] w;
    logic        two;
    w     = mem_rd(AW'(pc));
    two   = (w[15:14] == 2'b11);
    e.op  = w[15:11];
    e.rs  = w[10:8];
    e.rd  = w[7:5];
    e.sh  = w[4:0];
    e.imm = two ? mem_rd(AW'(pc + 32'd1)) : 16'h0000;
    e.next = pc + (two ? 32'd2 : 32'd1);
    return e;
  endfunction

  function automatic logic [31:0] reset_pc_model();
`ifdef FETCH_RESET_VECTOR_EN
    return {mem_rd(AW'(0)), mem_rd(AW'(1))};
`else
    return 32'h0000_0000;
`endif
  endfunction

  task automatic seed(input logic [31:0] start);
    exp_q.delete();
    exp_q.push_back(decode_at(start));
    for (int i = 0; i < 7; i++) exp_q.push_back(decode_at(exp_q[$].next));
  endtask

  // Keep the predicted stream topped up
  always @(posedge clk) begin
    while (exp_q.size() > 0 && exp_q.size() < 6)
      exp_q.push_back(decode_at(exp_q[$].next));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- memory responder with programmable wait states -------
  int          wmin = 0;
  int          wmax = 0;
  int          resp_cnt = 0;
  int          resp_wait = 0;
  logic        resp_busy = 1'b0;
  logic [AW-1:0] resp_addr = '0;

  always @(negedge clk) begin
    if (!bus.imem_req) begin
      resp_busy      = 1'b0;
      resp_cnt       = 0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 16'($urandom);
    end else begin
      if (!resp_busy || bus.imem_addr != resp_addr) begin
        resp_busy = 1'b1;
        resp_addr = bus.imem_addr;
        resp_cnt  = 0;
        resp_wait = $urandom_range(wmax, wmin);
      end
      if (resp_cnt >= resp_wait) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_rd(bus.imem_addr);
        resp_busy      = 1'b0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        resp_cnt++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic mon_en = 1'b0;
  logic hold_prev = 1'b0;
  exp_t snap;
  exp_t act_m;
  exp_t exp_m;
  int   idle = 0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      act_m = {bus.opcode, bus.Rs, bus.Rd, bus.shmnt, bus.imm, bus.Next_inst_addr};
      if (bus.inst_valid) begin
        idle = 0;
        chk("req_while_valid", 64'(bus.imem_req), 64'd0);
        if (hold_prev) chk("stall_hold_fields", act_m, snap);
        if (!bus.stall && !bus.redirect) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL inst_unexpected: got %0h, required none (cycle %0d)", act_m, cyc);
          end else begin
            exp_m = exp_q.pop_front();
            chk("inst", act_m, exp_m);
            n_consumed++;
          end
          hold_prev = 1'b0;
        end else begin
          hold_prev = bus.stall && !bus.redirect;
          snap      = act_m;
        end
      end else begin
        if (hold_prev) chk("stall_hold_valid", 64'(bus.inst_valid), 64'd1);
        hold_prev = 1'b0;
        idle++;
        if (idle > 150) begin
          n_checks++;
          n_errors++;
          $display("FAIL progress: got %0d idle cycles, required at most 150", idle);
          idle = 0;
        end
      end
    end else begin
      hold_prev = 1'b0;
      idle      = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int c);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.inst_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("valid_timeout", 64'(bus.inst_valid), 64'd1);
    c = cyc;
  endtask

  initial begin
    int   c1, c2, c3, c4, c5, cs;
    exp_t hold_snap;
    logic found;
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 32'h0;
    mem[0] = 16'h0A45; mem[1] = 16'h1234; mem[2] = 16'h2000;
    mem[3] = 16'h0800; mem[4] = 16'hC8E1; mem[5] = 16'hBEEF;
    mem[32'h000F_FFFF] = 16'h0800;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_fields", {bus.opcode, bus.Rs, bus.Rd, bus.shmnt, bus.imm}, 64'd0);
    chk("rst_next", 64'(bus.Next_inst_addr), 64'd0);

    drive_tick();
    rst = 1'b0;
    seed(reset_pc_model());
    mon_en = 1'b1;
    @(negedge clk);
    chk("req_low_after_rst", 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    chk("first_req", 64'(bus.imem_req), 64'd1);
`ifndef FETCH_RESET_VECTOR_EN
    chk("first_addr", 64'(bus.imem_addr), 64'd0);
`endif

    // One-word run, zero-wait memory
    wait_valid(c1);
`ifndef FETCH_RESET_VECTOR_EN
    chk("first_opcode", 64'(bus.opcode), 64'h01);
    chk("first_rs_rd_sh", {bus.Rs, bus.Rd, bus.shmnt}, {3'd2, 3'd2, 5'd5});
    chk("first_next", 64'(bus.Next_inst_addr), 64'd1);
`endif
    wait_valid(c2);
    wait_valid(c3);
    chk("spacing_1_2", 64'(c2 - c1), 64'd2);
    chk("spacing_2_3", 64'(c3 - c2), 64'd2);

`ifndef FETCH_RESET_VECTOR_EN
    // Two-word instruction at pc=4
    wait_valid(c4);
    wait_valid(c5);
    chk("two_word_latency", 64'(c5 - c4), 64'd3);
    chk("two_word_opcode", 64'(bus.opcode), 64'h19);
    chk("two_word_imm", 64'(bus.imm), 64'hBEEF);
    chk("two_word_next", 64'(bus.Next_inst_addr), 64'd6);
    @(negedge clk);
    chk("addr_after_two_word", {31'd0, bus.imem_req, 12'd0, bus.imem_addr}, {31'd0, 1'b1, 32'd6});
`endif

    // Stall held five cycles in PRESENT
    drive_tick();
    bus.stall = 1'b1;
    wait_valid(cs);
    hold_snap = {bus.opcode, bus.Rs, bus.Rd, bus.shmnt, bus.imm, bus.Next_inst_addr};
    repeat (5) begin
      @(negedge clk);
      chk("stall_fields", {bus.opcode, bus.Rs, bus.Rd, bus.shmnt, bus.imm, bus.Next_inst_addr}, hold_snap);
      chk("stall_valid_req", {bus.inst_valid, bus.imem_req}, 64'b10);
    end
    drive_tick();
    bus.stall = 1'b0;
    @(negedge clk);
    chk("release_valid", 64'(bus.inst_valid), 64'd1);
    @(negedge clk);
    chk("resume_req", {bus.inst_valid, bus.imem_req}, 64'b01);

    // Redirect coinciding with the ack of a 2-wait fetch
    wmin = 2; wmax = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive_tick();
      if (bus.imem_req && resp_busy && bus.imem_addr == resp_addr &&
          resp_cnt == resp_wait && resp_wait == 2)
        found = 1'b1;
    end
    chk("redirect_window_found", 64'(found), 64'd1);
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h0000_0040;
    seed(32'h0000_0040);
    drive_tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("redirect_req_addr", {bus.inst_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, AW'(32'h40)});

    // PC wrap
    wmin = 0; wmax = 0;
    drive_tick();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'hFFFF_FFFF;
    seed(32'hFFFF_FFFF);
    drive_tick();
    bus.redirect = 1'b0;
    wait_valid(c1);
    chk("wrap_next", 64'(bus.Next_inst_addr), 64'd0);
    chk("wrap_opcode", 64'(bus.opcode), 64'h01);
    @(negedge clk);
    chk("wrap_fetch_addr", {bus.imem_req, bus.imem_addr}, {1'b1, AW'(0)});

    // Reset mid-fetch together with a redirect: reset wins
    wmin = 2; wmax = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive_tick();
      if (bus.imem_req) found = 1'b1;
    end
    chk("rst_window_found", 64'(found), 64'd1);
    rst               = 1'b1;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h0000_0077;
    seed(reset_pc_model());
    drive_tick();
    rst          = 1'b0;
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("midrst_req_valid", {bus.inst_valid, bus.imem_req}, 64'b00);
    @(negedge clk);
    chk("midrst_refetch_req", 64'(bus.imem_req), 64'd1);
`ifndef FETCH_RESET_VECTOR_EN
    chk("midrst_refetch_addr", 64'(bus.imem_addr), 64'd0);
`endif

    // Randomized traffic
    wmin = 0; wmax = 3;
    repeat (600) begin
      drive_tick();
      bus.stall    = ($urandom % 100) < 30;
      bus.redirect = ($urandom % 100) < 4;
      if (bus.redirect) begin
        if (($urandom % 4) == 0) bus.redirect_addr = 32'hFFFF_FFF8 + ($urandom % 8);
        else                     bus.redirect_addr = $urandom_range(255, 0);
        seed(bus.redirect_addr);
      end
    end
    drive_tick();
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    repeat (20) @(negedge clk);
    chk("consumed_enough", 64'(n_consumed >= 60), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
